// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle logic/arith/compare ops and iterative
// multiply (shift-add) and unsigned divide/remainder (restoring shift-subtract).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      operation request, sampled only while busy=0
//   ina, inb   operands (dividend / divisor for DIVU and REMU)
//   incontrol  4-bit opcode, sampled with start
//   out        registered result, held until the next completion
//   zero       1 when out == 0
//   busy       high while an iterative op is in progress
//   done       one-cycle pulse marking the cycle in which out is valid
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic [3:0]       incontrol,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSltu = 4'b1000;
    localparam logic [3:0] OpNor  = 4'b1100;
    localparam logic [3:0] OpMul  = 4'b1010;
    localparam logic [3:0] OpDivu = 4'b1101;
    localparam logic [3:0] OpRemu = 4'b1110;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    // StMul: a = multiplicand (shifts left), b = multiplier (shifts right), acc = product.
    // StDiv: a = dividend shifting out / quotient shifting in, b = divisor, acc = remainder.
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  alu_res;
    logic [WIDTH-1:0]  mul_acc;
    logic [WIDTH:0]    rem_shift;
    logic [WIDTH:0]    rem_diff;
    logic              rem_fits;

    // Single-cycle result from the live inputs.
    always_comb begin
        alu_res = ina + inb;
        unique case (incontrol)
            OpAnd:   alu_res = ina & inb;
            OpOr:    alu_res = ina | inb;
            OpSub:   alu_res = ina - inb;
            // Direct signed compare, so operand overflow cannot flip the answer.
            OpSlt:   alu_res = WIDTH'($signed(ina) < $signed(inb));
            OpSltu:  alu_res = WIDTH'(ina < inb);
            OpNor:   alu_res = ~(ina | inb);
            default: alu_res = ina + inb;
        endcase
    end

    // One iteration of each iterative datapath.
    always_comb begin
        mul_acc   = b_q[0] ? (acc_q + a_q) : acc_q;
        rem_shift = {acc_q, a_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        // Top bit of the difference is the borrow; divisor 0 always fits, giving
        // an all-ones quotient and the dividend as remainder.
        rem_fits  = ~rem_diff[WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (incontrol == OpMul || incontrol == OpDivu || incontrol == OpRemu) begin
                        op_d    = incontrol;
                        a_d     = ina;
                        b_d     = inb;
                        acc_d   = '0;
                        cnt_d   = CntW'(WIDTH);
                        state_d = (incontrol == OpMul) ? StMul : StDiv;
                    end else begin
                        out_d  = alu_res;
                        done_d = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d = mul_acc;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    out_d   = mul_acc;
                    done_d  = 1'b1;
                end
            end
            StDiv: begin
                if (rem_fits) begin
                    acc_d = rem_diff[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_shift[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    out_d   = (op_q == OpRemu) ? acc_d : a_d;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign zero = (out_q == '0);
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized stimulus for alu_seq, checked against a
// behavioural model written with plain arithmetic.
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] ina;
    logic [W-1:0] inb;
    logic [3:0]   incontrol;
    logic [W-1:0] out;
    logic         zero;
    logic         busy;
    logic         done;

    int n_cmp;
    int n_err;
    logic [W-1:0] last_res;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ina       (ina),
        .inb       (inb),
        .incontrol (incontrol),
        .out       (out),
        .zero      (zero),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint unsigned prod;
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
            4'b1000: return (a < b) ? 1 : 0;
            4'b1100: return ~(a | b);
            4'b1010: begin
                prod = longint'(a) * longint'(b);
                return prod[W-1:0];
            end
            4'b1101: return (b == 0) ? {W{1'b1}} : a / b;
            4'b1110: return (b == 0) ? a : a % b;
            default: return a + b;
        endcase
    endfunction

    function automatic bit is_iter(input logic [3:0] op);
        return op == 4'b1010 || op == 4'b1101 || op == 4'b1110;
    endfunction

    // Called at #1 after a posedge with busy=0; returns at #1 after the edge
    // that makes done visible, so the next call issues back-to-back.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] exp;
        int           cycles;
        int           lat_exp;
        exp     = model(op, a, b);
        lat_exp = is_iter(op) ? W + 1 : 1;
        start     = 1'b1;
        incontrol = op;
        ina       = a;
        inb       = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < 200) begin
            check_eq("busy_during_op", busy, 1);
            check_eq("out_hold", out, last_res);
            if (cycles == 5) begin
                // Stray request while busy must be ignored.
                start     = 1'b1;
                incontrol = 4'($urandom);
                ina       = $urandom;
                inb       = $urandom;
            end else if (cycles == 6) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
        check_eq($sformatf("latency_op%0h", op), cycles, lat_exp);
        check_eq($sformatf("out_op%0h_%0h_%0h", op, a, b), out, exp);
        check_eq("zero", zero, exp == 0);
        check_eq("busy_at_done", busy, 0);
        last_res = exp;
    endtask

    task automatic idle_check(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_eq("idle_done", done, 0);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_out", out, last_res);
        end
    endtask

    logic [3:0] ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                             4'b1000, 4'b1100, 4'b1010, 4'b1101, 4'b1110};

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return W'($urandom_range(0, 15));
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] op;
        n_cmp     = 0;
        n_err     = 0;
        last_res  = '0;
        reset     = 1'b1;
        start     = 1'b0;
        ina       = '0;
        inb       = '0;
        incontrol = '0;

        // Two reset cycles; the second carries a request that reset must drop.
        @(posedge clk);
        #1;
        start     = 1'b1;
        incontrol = 4'b0010;
        ina       = 3;
        inb       = 4;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        check_eq("rst_out", out, 0);
        check_eq("rst_zero", zero, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        idle_check(5);

        do_op(4'b0110, 5, 5);
        do_op(4'b1100, 0, 0);
        do_op(4'b1111, 3, 4);
        do_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);
        do_op(4'b1000, 32'h7FFF_FFFF, 32'h8000_0000);
        do_op(4'b0111, 32'h8000_0000, 1);
        idle_check(1);

        do_op(4'b1010, 32'hFFFF_FFFF, 3);
        idle_check(1);
        do_op(4'b1101, 100, 7);
        do_op(4'b1110, 100, 7);
        do_op(4'b1101, 9, 0);
        do_op(4'b1110, 9, 0);
        idle_check(2);

        // Reset during busy cycle 10 of a multiply.
        start     = 1'b1;
        incontrol = 4'b1010;
        ina       = 123;
        inb       = 456;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("mid_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        last_res = '0;
        check_eq("midrst_out", out, 0);
        check_eq("midrst_zero", zero, 1);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        idle_check(W + 2);
        do_op(4'b0010, 1, 1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) op = 4'($urandom);
            else op = ops[$urandom_range(0, 9)];
            do_op(op, rand_operand(), rand_operand());
        end
        idle_check(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
